// File: rtl/vga_vsync_gen.sv
// Vertical VGA timing: counts line_end pulses into V_count, registers VSYNC/v_display/v_state/frame_start.
// Latency: outputs change on the edge that accepts line_end; V_counter_enable is combinational (enable & line_end).
// Backpressure: none; enable=0 freezes all state. Optional frame counter under `VGA_FRAME_CNT_EN.
module vga_vsync_gen #(
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 29,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             line_end,
  output logic [CNT_W-1:0] V_count,
  output logic             V_counter_enable,
  output logic             VSYNC,
  output logic             v_display,
  output logic [1:0]       v_state,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DISP_START  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(V_SYNC + V_BACK + V_DISP);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_BACK  = 2'd1,
    ST_DISP  = 2'd2,
    ST_FRONT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vsync_q, vsync_d;
  logic             disp_q, disp_d;
  logic             fs_q, fs_d;
  logic             adv, wrap;

  assign adv  = enable & line_end;
  assign wrap = adv && (count_q == LAST);

  // State and decoded outputs follow the next count so they line up with V_count.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (adv) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
      case (state_q)
        ST_SYNC:  if (count_d == BACK_START)  state_d = ST_BACK;
        ST_BACK:  if (count_d == DISP_START)  state_d = ST_DISP;
        ST_DISP:  if (count_d == FRONT_START) state_d = ST_FRONT;
        ST_FRONT: if (count_d == '0)          state_d = ST_SYNC;
        default:                              state_d = ST_SYNC;
      endcase
    end
    vsync_d = (state_d != ST_SYNC);
    disp_d  = (state_d == ST_DISP);
    fs_d    = wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      state_q <= ST_SYNC;
      vsync_q <= 1'b0;
      disp_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
      fs_q    <= fs_d;
    end
  end

  assign V_count          = count_q;
  assign V_counter_enable = adv;
  assign VSYNC            = vsync_q;
  assign v_display        = disp_q;
  assign v_state          = state_q;
  assign frame_start      = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = wrap ? fcnt_q + 8'd1 : fcnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fcnt_q <= 8'd0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`else
  // Frame counter not built in this configuration.
`endif

endmodule

// File: tb/tb_vga_vsync_gen.sv
// Directed bench for vga_vsync_gen: stimulus queues hand-computed expectations, a negedge monitor pops and compares.
module tb_vga_vsync_gen;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             line_end = 1'b0;
  logic [CNT_W-1:0] V_count;
  logic             V_counter_enable;
  logic             VSYNC;
  logic             v_display;
  logic [1:0]       v_state;
  logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  vga_vsync_gen #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .line_end         (line_end),
    .V_count          (V_count),
    .V_counter_enable (V_counter_enable),
    .VSYNC            (VSYNC),
    .v_display        (v_display),
    .v_state          (v_state),
    .frame_start      (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt        (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ven;
    bit vs;
    bit disp;
    int st;
    bit fs;
    int fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string nm, input int cnt, input bit ven, input bit vs,
                     input bit disp, input int st, input bit fs, input int fc = -1);
    exp_t e;
    e.cnt = cnt; e.ven = ven; e.vs = vs; e.disp = disp; e.st = st; e.fs = fs; e.fc = fc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input bit le, input bit en);
    @(posedge clk);
    #1;
    line_end = le;
    enable   = en;
  endtask

  // n consecutive accepted pulses, then line_end low; the next negedge shows the advanced count
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      bit    bad;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      bad = (V_count !== CNT_W'(e.cnt)) || (V_counter_enable !== e.ven) ||
            (VSYNC !== e.vs) || (v_display !== e.disp) ||
            (v_state !== 2'(e.st)) || (frame_start !== e.fs);
`ifdef VGA_FRAME_CNT_EN
      if (e.fc >= 0 && frame_cnt !== 8'(e.fc)) bad = 1'b1;
`endif
      n_chk++;
      if (bad)
        $display("FAIL %s: got cnt=%0d ven=%b vsync=%b disp=%b st=%0d fs=%b, want cnt=%0d ven=%b vsync=%b disp=%b st=%0d fs=%b fc=%0d",
                 nm, V_count, V_counter_enable, VSYNC, v_display, v_state, frame_start,
                 e.cnt, e.ven, e.vs, e.disp, e.st, e.fs, e.fc);
      else
        n_pass++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: first lines of the frame
    drive(1'b1, 1'b1); chk("t1_line0_strobe", 0, 1, 0, 0, 0, 0);
    drive(1'b1, 1'b1); chk("t1_line1", 1, 1, 0, 0, 0, 0);
    drive(1'b0, 1'b1); chk("t1_line2_back", 2, 0, 1, 0, 1, 0);

    // 2: back porch -> display
    advance(28);       chk("t2_line30", 30, 0, 1, 0, 1, 0);
    drive(1'b1, 1'b1); chk("t2_line30_strobe", 30, 1, 1, 0, 1, 0);
    drive(1'b0, 1'b1); chk("t2_line31_disp", 31, 0, 1, 1, 2, 0);

    // 3: display -> front porch -> wrap
    advance(479);      chk("t3_line510", 510, 0, 1, 1, 2, 0);
    drive(1'b1, 1'b1); chk("t3_line510_strobe", 510, 1, 1, 1, 2, 0);
    drive(1'b0, 1'b1); chk("t3_line511_front", 511, 0, 1, 0, 3, 0);
    advance(9);        chk("t3_line520", 520, 0, 1, 0, 3, 0);
    drive(1'b1, 1'b1); chk("t3_line520_strobe", 520, 1, 1, 0, 3, 0);
    drive(1'b0, 1'b1); chk("t3_wrap_frame_start", 0, 0, 0, 0, 0, 1, 1);
    drive(1'b0, 1'b1); chk("t3_frame_start_clear", 0, 0, 0, 0, 0, 0, 1);

    // 4: enable low ignores pulses
    advance(100);      chk("t4_line100", 100, 0, 1, 1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0); chk("t4_frozen", 100, 0, 1, 1, 2, 0);
    end
    drive(1'b0, 1'b1); chk("t4_no_queued_pulses", 100, 0, 1, 1, 2, 0);
    advance(2);        chk("t4_back_to_back", 102, 0, 1, 1, 2, 0);

    // 5: asynchronous reset mid-cycle
    advance(198);      chk("t5_line300", 300, 0, 1, 1, 2, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    chk("t5_async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    advance(1);        chk("t5_after_release", 1, 0, 0, 0, 0, 0, 0);

    // 6: three full frames from a fresh reset
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    advance(1563);     chk("t6_three_frames", 0, 0, 0, 0, 0, 1, 3);
    drive(1'b0, 1'b1); chk("t6_frame_start_clear", 0, 0, 0, 0, 0, 0, 3);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_vsync_gen.md
Name: vga_vsync_gen

Overview:
Vertical timing generator for the VGA output path. It counts display lines using the end-of-line pulse from the horizontal timing generator. From that count it produces the active-low VSYNC, the vertical display window and the line-advance strobe.
It sits directly upstream of the vertical line-replication counter (x5 line multiplier) and feeds it V_count and V_counter_enable. Line replication relies on V_counter_enable being coincident with the pre-increment V_count.

Parameters:
V_SYNC, 2, lines in sync pulse (phase starts at line 0)
V_BACK, 29, back-porch lines (lines 2..30 with defaults)
V_DISP, 480, visible lines (lines 31..510 with defaults)
V_FRONT, 10, front-porch lines (lines 511..520 with defaults)
CNT_W, 12, width of V_count

Ports:
clk  in  1  system pixel clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run enable; 0 freezes all state
line_end  in  1  one-cycle pulse from horizontal generator, last pixel clock of each line
V_count  out  CNT_W  current line number, 0..V_TOTAL-1 (V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT = 521)
V_counter_enable  out  1  line-advance strobe to downstream stages
VSYNC  out  1  vertical sync, active-low
v_display  out  1  high during visible lines
v_state  out  2  phase: 0=SYNC, 1=BACK, 2=DISP, 3=FRONT
frame_start  out  1  one-cycle pulse, first clock of line 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, named reset.
- Reset values (reset=0, takes effect immediately, independent of clk):
  - V_count=0, v_state=SYNC, VSYNC=0, v_display=0, frame_start=0.
  - V_counter_enable=0, because it is gated by enable/line_end.
- V_counter_enable is combinational: enable & line_end. It is high in the same cycle as the line's final V_count value, before the increment.
  - Example: V_counter_enable=1 while V_count=30 is the last back-porch strobe.
- Line counter: on posedge clk with V_counter_enable=1:
  - V_count == V_TOTAL-1 → V_count=0;
  - otherwise → V_count+1.
  - No change when V_counter_enable=0.
- FSM is registered and updated on the same edge as V_count, from the next count value:
  - SYNC→BACK when next count = V_SYNC (2)
  - BACK→DISP when next count = V_SYNC+V_BACK (31)
  - DISP→FRONT when next count = V_SYNC+V_BACK+V_DISP (511)
  - FRONT→SYNC when the count wraps to 0
  - No other transitions; the state changes only on an accepted line_end.
- Registered outputs, decoded from the next state, so they are aligned with V_count (zero-cycle skew):
  - VSYNC = 0 iff state is SYNC.
  - v_display = 1 iff state is DISP.
- frame_start = 1 for exactly one cycle, the cycle after the wrap edge (V_count now 0); otherwise 0.
- enable=0:
  - line_end pulses are ignored and not queued.
  - All outputs hold their values; frame_start clears to 0 after one cycle as normal.
- Reset mid-frame: immediate return to line 0 / SYNC. The first accepted line_end after release moves to line 1.
- line_end asserted on consecutive cycles: each asserted cycle counts as one line (no edge detection).
- Width rule: V_TOTAL-1 must fit in CNT_W bits. There is no saturation; the wrap is explicit.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt [7:0], reset to 0.
  - Increments on each wrap (the same edge that raises frame_start); wraps 255→0.
  - Frozen while enable=0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, enable=1, 2 line_end pulses → V_count 0→1→2, VSYNC 0→0→1, v_state SYNC→SYNC→BACK.
2. Drive to V_count=30, pulse line_end → V_counter_enable=1 in that cycle with V_count=30; next cycle V_count=31, v_display=1, v_state=DISP.
3. Drive to V_count=510, pulse → V_count=511, v_display=0, v_state=FRONT.
   - Drive to 520, pulse → V_count=0, VSYNC=0, frame_start=1 for one cycle only.
4. enable=0 with 5 line_end pulses at V_count=100 → V_count stays 100, V_counter_enable stays 0, v_display stays 1.
5. Assert reset asynchronously mid-cycle at V_count=300 → outputs at reset values before the next clk edge; after release, 1 pulse → V_count=1.
6. With VGA_FRAME_CNT_EN: run 3 full frames (1563 pulses) → frame_cnt=3.
   - Preload 255 and wrap once → frame_cnt=0.
